// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   NOP     - canonical bubble instruction (addi x0,x0,0)
//   state_t - fetch read-tracking FSM states
//   entry_t - instruction queue entry {instr, pc}
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    // RUN : no read outstanding
    // WAIT: one read outstanding, its data will be kept
    // DROP: one read outstanding, its data will be discarded
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory read bus.
//   imem_req    - read request (fetch -> memory), always accepted
//   imem_addr   - word address of the request
//   imem_rvalid - read data valid (memory -> fetch), >= 1 cycle after request
//   imem_rdata  - returned instruction word
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_if #(
    parameter int unsigned WIDTH = 32
);

    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO buffering fetched instructions.
//   clk, rst  - clock, asynchronous active-high reset (to empty)
//   push      - write push_data at the tail
//   pop       - drop the head entry
//   clear     - empty the FIFO; overrides push and pop
//   push_data - entry to write
//   count     - number of valid entries (0..2)
//   head      - oldest entry (meaningful when count != 0)
module fetch_queue
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  entry_t     push_data,
    output logic [1:0] count,
    output entry_t     head
);

    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/top_fetch.sv
// top_fetch: RV32I fetch stage. Owns PC_F, issues word reads to instruction
// memory (at most one outstanding), buffers returns in a 2-entry queue and
// drives the F/D pipeline register. A decode redirect squashes everything.
//   clk, rst          - clock, asynchronous active-high reset
//   stall_D           - decode cannot accept; F/D register holds
//   PCsrc_D           - redirect request from decode
//   PCtarget_D        - redirect target (bits [1:0] ignored)
//   imem              - instruction memory bus (master side)
//   instr_D           - instruction to decode (NOP when bubble)
//   PC_D, PCPlus4_D   - PC of instr_D and PC_D + 4
//   valid_D           - instr_D is a real instruction
module top_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_D,
    input  logic             PCsrc_D,
    input  logic [WIDTH-1:0] PCtarget_D,
    fetch_if.master          imem,
    output logic [WIDTH-1:0] instr_D,
    output logic [WIDTH-1:0] PC_D,
    output logic [WIDTH-1:0] PCPlus4_D,
    output logic             valid_D
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_f_q, pc_f_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [WIDTH-1:0] fd_instr_q, fd_instr_d;
    logic [WIDTH-1:0] fd_pc_q, fd_pc_d;
    logic [WIDTH-1:0] fd_pc4_q, fd_pc4_d;
    logic             fd_valid_q, fd_valid_d;

    logic       push, pop, req;
    logic [1:0] q_count, count_after;
    entry_t     q_head, q_in;

    // A new request is only issued if, after this cycle's push/pop, there is
    // still room for its data, so a returned word can always be enqueued.
    always_comb begin
        push        = (state_q == WAIT) && imem.imem_rvalid && !PCsrc_D;
        pop         = !PCsrc_D && !stall_D && (q_count != 2'd0);
        count_after = q_count + {1'b0, push} - {1'b0, pop};
        req         = !rst && !PCsrc_D
                      && ((state_q == RUN) || ((state_q == WAIT) && imem.imem_rvalid))
                      && (count_after < 2'd2);
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_f_q;
    assign q_in           = '{instr: imem.imem_rdata, pc: pend_pc_q};

    fetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (PCsrc_D),
        .push_data (q_in),
        .count     (q_count),
        .head      (q_head)
    );

    always_comb begin
        state_d    = state_q;
        pc_f_d     = pc_f_q;
        pend_pc_d  = pend_pc_q;
        fd_instr_d = fd_instr_q;
        fd_pc_d    = fd_pc_q;
        fd_pc4_d   = fd_pc4_q;
        fd_valid_d = fd_valid_q;

        if (PCsrc_D) begin
            // Redirect beats stall: bubble F/D, retarget, and remember that an
            // in-flight read (if still pending) must be thrown away.
            pc_f_d     = PCtarget_D & ~WIDTH'(3);
            fd_instr_d = NOP;
            fd_valid_d = 1'b0;
            case (state_q)
                WAIT:    state_d = imem.imem_rvalid ? RUN : DROP;
                DROP:    state_d = imem.imem_rvalid ? RUN : DROP;
                default: state_d = RUN;
            endcase
        end else begin
            case (state_q)
                RUN:     if (req) state_d = WAIT;
                WAIT:    if (imem.imem_rvalid) state_d = req ? WAIT : RUN;
                DROP:    if (imem.imem_rvalid) state_d = RUN;
                default: state_d = RUN;
            endcase
            if (req) begin
                pend_pc_d = pc_f_q;
                pc_f_d    = pc_f_q + WIDTH'(4);
            end
            if (!stall_D) begin
                if (pop) begin
                    fd_instr_d = q_head.instr;
                    fd_pc_d    = q_head.pc;
                    fd_pc4_d   = q_head.pc + 32'd4;
                    fd_valid_d = 1'b1;
                end else begin
                    fd_instr_d = NOP;
                    fd_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_f_q     <= RESET_PC;
            pend_pc_q  <= '0;
            fd_instr_q <= NOP;
            fd_pc_q    <= '0;
            fd_pc4_q   <= '0;
            fd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_f_q     <= pc_f_d;
            pend_pc_q  <= pend_pc_d;
            fd_instr_q <= fd_instr_d;
            fd_pc_q    <= fd_pc_d;
            fd_pc4_q   <= fd_pc4_d;
            fd_valid_q <= fd_valid_d;
        end
    end

    assign instr_D   = fd_instr_q;
    assign PC_D      = fd_pc_q;
    assign PCPlus4_D = fd_pc4_q;
    assign valid_D   = fd_valid_q;

endmodule

// File: tb/tb_top_fetch.sv
module tb_top_fetch;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    typedef struct {
        logic        stall;
        logic        pcsrc;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] p4;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        stall_D;
    logic        PCsrc_D;
    logic [31:0] PCtarget_D;
    logic [31:0] instr_D, PC_D, PCPlus4_D;
    logic        valid_D;

    logic        zero_b;
    logic [31:0] zero_w;
    logic [31:0] w_instr_D, w_PC_D, w_PCPlus4_D;
    logic        w_valid_D;

    int n_cmp;
    int n_fail;
    int lat;

    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_addr;

    vec_t vt [34];

    fetch_if #(.WIDTH(32)) if1 ();
    fetch_if #(.WIDTH(32)) if2 ();

    top_fetch #(.WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .stall_D    (stall_D),
        .PCsrc_D    (PCsrc_D),
        .PCtarget_D (PCtarget_D),
        .imem       (if1),
        .instr_D    (instr_D),
        .PC_D       (PC_D),
        .PCPlus4_D  (PCPlus4_D),
        .valid_D    (valid_D)
    );

    top_fetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .stall_D    (zero_b),
        .PCsrc_D    (zero_b),
        .PCtarget_D (zero_w),
        .imem       (if2),
        .instr_D    (w_instr_D),
        .PC_D       (w_PC_D),
        .PCPlus4_D  (w_PCPlus4_D),
        .valid_D    (w_valid_D)
    );

    function automatic logic [31:0] W(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory for the main DUT: fixed latency 'lat' cycles after the request.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy          <= 1'b0;
            m_cnt           <= 0;
            m_addr          <= '0;
            if1.imem_rvalid <= 1'b0;
            if1.imem_rdata  <= '0;
        end else begin
            if1.imem_rvalid <= 1'b0;
            if (m_busy) begin
                if (m_cnt <= 1) begin
                    if1.imem_rvalid <= 1'b1;
                    if1.imem_rdata  <= W(m_addr);
                    m_busy          <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (if1.imem_req) begin
                if (lat <= 1) begin
                    if1.imem_rvalid <= 1'b1;
                    if1.imem_rdata  <= W(if1.imem_addr);
                end else begin
                    m_busy <= 1'b1;
                    m_addr <= if1.imem_addr;
                    m_cnt  <= lat - 1;
                end
            end
        end
    end

    // Memory for the wrap-around DUT: always 1-cycle latency.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if2.imem_rvalid <= 1'b0;
            if2.imem_rdata  <= '0;
        end else begin
            if2.imem_rvalid <= if2.imem_req;
            if2.imem_rdata  <= W(if2.imem_addr);
        end
    end

    function automatic vec_t mk(input logic s, input logic p, input logic [31:0] t,
                                input logic r, input logic [31:0] a, input logic v,
                                input logic [31:0] i, input logic [31:0] pc,
                                input logic [31:0] p4);
        vec_t x;
        x.stall = s; x.pcsrc = p; x.tgt = t;
        x.req = r; x.addr = a; x.valid = v; x.instr = i; x.pc = pc; x.p4 = p4;
        return x;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %08h expected %08h", nm, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        stall_D    = 1'b0;
        PCsrc_D    = 1'b0;
        PCtarget_D = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Entry 'lo' is applied in the current cycle (caller sits on a falling edge).
    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (i != lo) @(negedge clk);
            stall_D    = vt[i].stall;
            PCsrc_D    = vt[i].pcsrc;
            PCtarget_D = vt[i].tgt;
            #1;
            chk("imem_req",  i, 32'(if1.imem_req), 32'(vt[i].req));
            chk("imem_addr", i, if1.imem_addr,     vt[i].addr);
            chk("valid_D",   i, 32'(valid_D),      32'(vt[i].valid));
            chk("instr_D",   i, instr_D,           vt[i].instr);
            chk("PC_D",      i, PC_D,              vt[i].pc);
            chk("PCPlus4_D", i, PCPlus4_D,         vt[i].p4);
        end
        stall_D = 1'b0;
        PCsrc_D = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        lat    = 1;
        zero_b = 1'b0;
        zero_w = '0;
        rst    = 1'b1;
        stall_D = 1'b0;
        PCsrc_D = 1'b0;
        PCtarget_D = '0;

        // Steady stream, 1-cycle memory, 5-cycle stall at cycles 5..9.
        vt[0]  = mk(0, 0, 0, 1, 32'd0,  0, NOP_W,   32'd0,  32'd0);
        vt[1]  = mk(0, 0, 0, 1, 32'd4,  0, NOP_W,   32'd0,  32'd0);
        vt[2]  = mk(0, 0, 0, 1, 32'd8,  0, NOP_W,   32'd0,  32'd0);
        vt[3]  = mk(0, 0, 0, 1, 32'd12, 1, W(0),    32'd0,  32'd4);
        vt[4]  = mk(0, 0, 0, 1, 32'd16, 1, W(4),    32'd4,  32'd8);
        for (int i = 5; i < 10; i++)
            vt[i] = mk(1, 0, 0, 0, 32'd20, 1, W(8), 32'd8, 32'd12);
        vt[10] = mk(0, 0, 0, 1, 32'd20, 1, W(8),    32'd8,  32'd12);
        vt[11] = mk(0, 0, 0, 1, 32'd24, 1, W(12),   32'd12, 32'd16);
        vt[12] = mk(0, 0, 0, 1, 32'd28, 1, W(16),   32'd16, 32'd20);
        vt[13] = mk(0, 0, 0, 1, 32'd32, 1, W(20),   32'd20, 32'd24);
        vt[14] = mk(0, 0, 0, 1, 32'd36, 1, W(24),   32'd24, 32'd28);

        // 3-cycle memory, redirect to 0x103 while the read of 0 is in flight.
        vt[15] = mk(0, 0, 0,            1, 32'h000, 0, NOP_W, 0, 0);
        vt[16] = mk(0, 1, 32'h0000_0103, 0, 32'h004, 0, NOP_W, 0, 0);
        vt[17] = mk(0, 0, 0,            0, 32'h100, 0, NOP_W, 0, 0);
        vt[18] = mk(0, 0, 0,            0, 32'h100, 0, NOP_W, 0, 0);
        vt[19] = mk(0, 0, 0,            1, 32'h100, 0, NOP_W, 0, 0);
        vt[20] = mk(0, 0, 0,            0, 32'h104, 0, NOP_W, 0, 0);
        vt[21] = mk(0, 0, 0,            0, 32'h104, 0, NOP_W, 0, 0);
        vt[22] = mk(0, 0, 0,            1, 32'h104, 0, NOP_W, 0, 0);
        vt[23] = mk(0, 0, 0,            0, 32'h108, 0, NOP_W, 0, 0);
        vt[24] = mk(0, 0, 0,            0, 32'h108, 1, W(32'h100), 32'h100, 32'h104);

        // 1-cycle memory, redirect + stall in the same cycle as rvalid.
        vt[25] = mk(0, 0, 0,            1, 32'd0,   0, NOP_W, 0, 0);
        vt[26] = mk(0, 0, 0,            1, 32'd4,   0, NOP_W, 0, 0);
        vt[27] = mk(0, 0, 0,            1, 32'd8,   0, NOP_W, 0, 0);
        vt[28] = mk(0, 0, 0,            1, 32'd12,  1, W(0),  32'd0, 32'd4);
        vt[29] = mk(1, 1, 32'h0000_0200, 0, 32'd16,  1, W(4),  32'd4, 32'd8);
        vt[30] = mk(0, 0, 0,            1, 32'h200, 0, NOP_W, 32'd4, 32'd8);
        vt[31] = mk(0, 0, 0,            1, 32'h204, 0, NOP_W, 32'd4, 32'd8);
        vt[32] = mk(0, 0, 0,            1, 32'h208, 0, NOP_W, 32'd4, 32'd8);
        vt[33] = mk(0, 0, 0,            1, 32'h20C, 1, W(32'h200), 32'h200, 32'h204);

        // Values while reset is held.
        #1;
        chk("rst_req",    0, 32'(if1.imem_req), 32'd0);
        chk("rst_addr",   0, if1.imem_addr,     32'd0);
        chk("rst_valid",  0, 32'(valid_D),      32'd0);
        chk("rst_instr",  0, instr_D,           NOP_W);
        chk("rst_pc",     0, PC_D,              32'd0);
        chk("rst_pc4",    0, PCPlus4_D,         32'd0);
        chk("wrst_addr",  0, if2.imem_addr,     32'hFFFF_FFF8);
        chk("wrst_req",   0, 32'(if2.imem_req), 32'd0);

        lat = 1;
        do_reset();
        run_table(0, 15);

        lat = 3;
        do_reset();
        run_table(15, 25);

        lat = 1;
        do_reset();
        run_table(25, 34);

        // Wrap-around DUT and asynchronous reset in the middle of a stream.
        lat = 1;
        do_reset();
        #1;
        chk("wrap_req",   0, 32'(if2.imem_req), 32'd1);
        chk("wrap_addr",  0, if2.imem_addr,     32'hFFFF_FFF8);
        @(negedge clk); #1;
        chk("wrap_addr",  1, if2.imem_addr,     32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("wrap_addr",  2, if2.imem_addr,     32'h0000_0000);
        chk("main_addr",  2, if1.imem_addr,     32'd8);
        @(negedge clk); #1;
        chk("wrap_valid", 3, 32'(w_valid_D),    32'd1);
        chk("wrap_instr", 3, w_instr_D,         W(32'hFFFF_FFF8));
        chk("wrap_pc",    3, w_PC_D,            32'hFFFF_FFF8);
        @(negedge clk); #1;
        chk("wrap_instr", 4, w_instr_D,         W(32'hFFFF_FFFC));
        chk("wrap_pc4",   4, w_PCPlus4_D,       32'h0000_0000);
        @(negedge clk); #1;
        chk("wrap_instr", 5, w_instr_D,         W(32'h0));
        chk("wrap_pc",    5, w_PC_D,            32'h0);
        chk("main_instr", 5, instr_D,           W(32'd8));
        #1;
        rst = 1'b1;
        #1;
        chk("mid_req",    0, 32'(if1.imem_req), 32'd0);
        chk("mid_addr",   0, if1.imem_addr,     32'd0);
        chk("mid_valid",  0, 32'(valid_D),      32'd0);
        chk("mid_instr",  0, instr_D,           NOP_W);
        chk("mid_pc",     0, PC_D,              32'd0);
        chk("mid_pc4",    0, PCPlus4_D,         32'd0);
        chk("mid_waddr",  0, if2.imem_addr,     32'hFFFF_FFF8);
        chk("mid_wvalid", 0, 32'(w_valid_D),    32'd0);
        chk("mid_wpc",    0, w_PC_D,            32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("restart_req",  0, 32'(if1.imem_req), 32'd1);
        chk("restart_addr", 0, if1.imem_addr,     32'd0);
        @(negedge clk); #1;
        chk("restart_addr", 1, if1.imem_addr,     32'd4);
        repeat (2) @(negedge clk);
        #1;
        chk("restart_valid", 3, 32'(valid_D),     32'd1);
        chk("restart_instr", 3, instr_D,          W(32'd0));
        chk("restart_pc",    3, PC_D,             32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
